alu_unit: RTL and testbench

Integer execute unit that sits downstream of the reservation station. Each cycle it accepts at most one issued micro-op (ROB id, opcode type, op, two operands). It computes the RV32I integer, branch-compare or address result and broadcasts it on the ALU result bus (CDB) one cycle later. Results flow back to the reservation station, ROB and register file. An optional iterative shifter adds a busy state and backpressure toward the reservation station.

---
 rtl/alu_unit.sv | 126 ++++++++++++
 tb/tb_alu_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// alu_unit: RV32I integer/branch/address execute unit; result appears on the CDB one cycle after issue.
// Define ALU_SERIAL_SHIFT_EN to swap the barrel shifter for a 1-bit/cycle shifter with backpressure.
module alu_unit (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _alu_ready,
    input  logic [4:0]  _alu_rob_id,
    input  logic [6:0]  _alu_type,
    input  logic [3:0]  _alu_op,
    input  logic [31:0] _alu_v1,
    input  logic [31:0] _alu_v2,
    output logic        _alu_full,
    output logic        _cdb_ready,
    output logic [4:0]  _cdb_rob_id,
    output logic [31:0] _cdb_value
);
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    logic [2:0]  f3;
    logic [4:0]  shamt;
    logic        lt_s, lt_u, sub_sra;
    logic [31:0] result;

    assign f3    = _alu_op[2:0];
    assign shamt = _alu_v2[4:0];
    assign lt_s  = $signed(_alu_v1) < $signed(_alu_v2);
    assign lt_u  = _alu_v1 < _alu_v2;

    // I-type only honours funct7[5] for SRAI; R-type honours it for SUB and SRA
    always_comb begin
        sub_sra = _alu_op[3] && (_alu_type == OP_R || f3 == 3'b101);
        result  = _alu_v1 + _alu_v2;
        if (_alu_type == OP_R || _alu_type == OP_I)
            case (f3)
                3'b000:  result = sub_sra ? _alu_v1 - _alu_v2 : _alu_v1 + _alu_v2;
                3'b001:  result = _alu_v1 << shamt;
                3'b010:  result = {31'd0, lt_s};
                3'b011:  result = {31'd0, lt_u};
                3'b100:  result = _alu_v1 ^ _alu_v2;
                3'b101:  result = sub_sra ? 32'($signed(_alu_v1) >>> shamt) : _alu_v1 >> shamt;
                3'b110:  result = _alu_v1 | _alu_v2;
                default: result = _alu_v1 & _alu_v2;
            endcase
        else if (_alu_type == OP_B)
            case (f3)
                3'b000:  result = {31'd0, _alu_v1 == _alu_v2};
                3'b001:  result = {31'd0, _alu_v1 != _alu_v2};
                3'b100:  result = {31'd0, lt_s};
                3'b101:  result = {31'd0, !lt_s};
                3'b110:  result = {31'd0, lt_u};
                3'b111:  result = {31'd0, !lt_u};
                default: result = 32'd0;
            endcase
    end

`ifdef ALU_SERIAL_SHIFT_EN
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, state_nxt;
    logic        serial, sh_left, sh_arith;
    logic [4:0]  sh_cnt, sh_rob;
    logic [31:0] sh_val, sh_step;

    // funct3 001/101 are the shifts; a zero shamt needs no iteration
    assign serial  = (_alu_type == OP_R || _alu_type == OP_I) && f3[1:0] == 2'b01 && shamt != 5'd0;
    assign sh_step = sh_left ? {sh_val[30:0], 1'b0} : {sh_arith & sh_val[31], sh_val[31:1]};

    always_comb begin
        _alu_full = state == SHIFT || (_alu_ready && serial);
        state_nxt = state == IDLE ? (_alu_ready && serial ? SHIFT : IDLE)
                                  : (sh_cnt == 5'd1 ? IDLE : SHIFT);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || _clear) begin
            state       <= IDLE;
            sh_cnt      <= 5'd0;
            _cdb_ready  <= 1'b0;
            _cdb_rob_id <= 5'd0;
            _cdb_value  <= 32'd0;
        end else if (rdy_in) begin
            state      <= state_nxt;
            _cdb_ready <= 1'b0;
            if (state == SHIFT) begin
                sh_val <= sh_step;
                sh_cnt <= sh_cnt - 5'd1;
                if (sh_cnt == 5'd1) begin
                    _cdb_ready  <= 1'b1;
                    _cdb_rob_id <= sh_rob;
                    _cdb_value  <= sh_step;
                end
            end else if (_alu_ready && serial) begin
                sh_val   <= _alu_v1;
                sh_cnt   <= shamt;
                sh_rob   <= _alu_rob_id;
                sh_left  <= !f3[2];
                sh_arith <= sub_sra;
            end else if (_alu_ready) begin
                _cdb_ready  <= 1'b1;
                _cdb_rob_id <= _alu_rob_id;
                _cdb_value  <= result;
            end
        end
    end
`else
    assign _alu_full = 1'b0;

    always_ff @(posedge clk_in) begin
        if (rst_in || _clear) begin
            _cdb_ready  <= 1'b0;
            _cdb_rob_id <= 5'd0;
            _cdb_value  <= 32'd0;
        end else if (rdy_in) begin
            _cdb_ready <= _alu_ready;
            if (_alu_ready) begin
                _cdb_rob_id <= _alu_rob_id;
                _cdb_value  <= result;
            end
        end
    end
`endif
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: vector table, corner-case sequences and random ops checked against a reference model.
module tb_alu_unit;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, _clear, _alu_ready;
    logic [4:0]  _alu_rob_id;
    logic [6:0]  _alu_type;
    logic [3:0]  _alu_op;
    logic [31:0] _alu_v1, _alu_v2;
    logic        _alu_full, _cdb_ready;
    logic [4:0]  _cdb_rob_id;
    logic [31:0] _cdb_value;
    int checks = 0, failures = 0;

    localparam logic [6:0] T_R = 7'b0110011, T_I = 7'b0010011, T_B = 7'b1100011;
    localparam logic [6:0] T_LUI = 7'b0110111, T_JAL = 7'b1101111;

    always #5 clk_in = ~clk_in;

    alu_unit dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(_clear),
        ._alu_ready(_alu_ready), ._alu_rob_id(_alu_rob_id), ._alu_type(_alu_type),
        ._alu_op(_alu_op), ._alu_v1(_alu_v1), ._alu_v2(_alu_v2), ._alu_full(_alu_full),
        ._cdb_ready(_cdb_ready), ._cdb_rob_id(_cdb_rob_id), ._cdb_value(_cdb_value)
    );

    typedef struct {
        logic [6:0]  t;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rob;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [6:0] t, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rob);
        _alu_ready = 1'b1;
        _alu_type = t;
        _alu_op = op;
        _alu_v1 = a;
        _alu_v2 = b;
        _alu_rob_id = rob;
    endtask

    function automatic logic [31:0] ref_alu(input logic [6:0] t, input logic [3:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        int sa = $signed(a);
        int sb = $signed(b);
        int sh = int'(b[4:0]);
        logic [31:0] fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        if (t == T_B)
            case (op[2:0])
                3'd0: return (a == b) ? 32'd1 : 32'd0;
                3'd1: return (a != b) ? 32'd1 : 32'd0;
                3'd4: return (sa < sb) ? 32'd1 : 32'd0;
                3'd5: return (sa >= sb) ? 32'd1 : 32'd0;
                3'd6: return (a < b) ? 32'd1 : 32'd0;
                3'd7: return (a >= b) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
        if (t != T_R && t != T_I) return a + b;
        case (op[2:0])
            3'd0: return (op[3] && t == T_R) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return op[3] ? ((a >> sh) | fill) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Extra cycles beyond the single-cycle path
    function automatic int ref_lat(input logic [6:0] t, input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_SERIAL_SHIFT_EN
        if ((t == T_R || t == T_I) && (op[2:0] == 3'd1 || op[2:0] == 3'd5)) return int'(b[4:0]);
`endif
        return 0;
    endfunction

    task automatic do_op(input string name, input logic [6:0] t, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rob);
        int lat = 0;
        int full_cycles;
        int exp_lat = ref_lat(t, op, b);
        logic [31:0] exp = ref_alu(t, op, a, b);
        drive(t, op, a, b, rob);
        #1;
        full_cycles = _alu_full ? 1 : 0;
        step;
        _alu_ready = 1'b0;
        while (!_cdb_ready && lat < 40) begin
            full_cycles += _alu_full ? 1 : 0;
            step;
            lat++;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " value"}, _cdb_value, exp);
        check({name, " rob"}, {27'd0, _cdb_rob_id}, {27'd0, rob});
        check({name, " full cycles"}, full_cycles, exp_lat == 0 ? 0 : exp_lat + 1);
        step;
        check({name, " pulse end"}, {31'd0, _cdb_ready}, 32'd0);
    endtask

    vec_t vecs[$];
    int pulses;

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; _clear = 1'b0; _alu_ready = 1'b0;
        _alu_rob_id = '0; _alu_type = '0; _alu_op = '0; _alu_v1 = '0; _alu_v2 = '0;
        step; step;
        rst_in = 1'b0;
        step;
        check("reset cdb_ready", {31'd0, _cdb_ready}, 32'd0);
        check("reset cdb_value", _cdb_value, 32'd0);
        check("reset cdb_rob", {27'd0, _cdb_rob_id}, 32'd0);
        check("reset full", {31'd0, _alu_full}, 32'd0);

        vecs = '{
            '{T_R,   4'b1000, 32'd5,          32'd7,          5'd3,  32'hFFFF_FFFE},
            '{T_R,   4'b0010, 32'hFFFF_FFFF,  32'd1,          5'd4,  32'd1},
            '{T_R,   4'b0011, 32'hFFFF_FFFF,  32'd1,          5'd5,  32'd0},
            '{T_B,   4'b0101, 32'hFFFF_FFFE,  32'hFFFF_FFFE,  5'd6,  32'd1},
            '{T_B,   4'b0001, 32'd4,          32'd4,          5'd7,  32'd0},
            '{T_JAL, 4'b0000, 32'h1000,       32'h20,         5'd8,  32'h1020},
            '{T_I,   4'b1000, 32'd10,         32'd3,          5'd9,  32'd13},
            '{T_R,   4'b0100, 32'hF0F0_F0F0,  32'hFF00_FF00,  5'd10, 32'h0FF0_0FF0},
            '{T_I,   4'b0110, 32'h1234_0000,  32'h5678,       5'd11, 32'h1234_5678},
            '{T_R,   4'b0111, 32'hFFFF_0000,  32'h0F0F_0F0F,  5'd12, 32'h0F0F_0000},
            '{T_R,   4'b0000, 32'hFFFF_FFFF,  32'd2,          5'd13, 32'd1},
            '{T_B,   4'b0110, 32'd1,          32'hFFFF_FFFF,  5'd14, 32'd1},
            '{T_B,   4'b0100, 32'hFFFF_FFFF,  32'd0,          5'd15, 32'd1},
            '{T_B,   4'b0000, 32'd7,          32'd7,          5'd16, 32'd1},
            '{T_B,   4'b0010, 32'd1,          32'd2,          5'd17, 32'd0},
            '{T_LUI, 4'b0000, 32'd0,          32'hABCD_E000,  5'd18, 32'hABCD_E000},
            '{T_R,   4'b0001, 32'h55,         32'h20,         5'd19, 32'h55}
        };
        foreach (vecs[i]) begin
            drive(vecs[i].t, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rob);
            step;
            check($sformatf("vec%0d ready", i), {31'd0, _cdb_ready}, 32'd1);
            check($sformatf("vec%0d rob", i), {27'd0, _cdb_rob_id}, {27'd0, vecs[i].rob});
            check($sformatf("vec%0d value", i), _cdb_value, vecs[i].exp);
        end
        _alu_ready = 1'b0;
        step;
        check("after table ready", {31'd0, _cdb_ready}, 32'd0);

        drive(T_R, 4'b0000, 32'd1, 32'd2, 5'd5);
        step;
        rdy_in = 1'b0;
        drive(T_R, 4'b1000, 32'd100, 32'd1, 5'd20);
        for (int i = 0; i < 3; i++) begin
            step;
            check("stall ready", {31'd0, _cdb_ready}, 32'd1);
            check("stall rob", {27'd0, _cdb_rob_id}, 32'd5);
            check("stall value", _cdb_value, 32'd3);
        end
        rdy_in = 1'b1;
        _alu_ready = 1'b0;
        step;
        check("stall release ready", {31'd0, _cdb_ready}, 32'd0);

        drive(T_R, 4'b0000, 32'd9, 32'd9, 5'd1);
        step;
        _alu_ready = 1'b0;
        rdy_in = 1'b0;
        rst_in = 1'b1;
        step;
        check("reset over rdy ready", {31'd0, _cdb_ready}, 32'd0);
        check("reset over rdy value", _cdb_value, 32'd0);
        rst_in = 1'b0;
        rdy_in = 1'b1;

        do_op("srai", T_I, 4'b1101, 32'h8000_0000, 32'd4, 5'd9);
        check("srai result", ref_alu(T_I, 4'b1101, 32'h8000_0000, 32'd4), 32'hF800_0000);

        drive(T_R, 4'b0000, 32'd1, 32'd1, 5'd2);
        _clear = 1'b1;
        step;
        _clear = 1'b0;
        _alu_ready = 1'b0;
        check("clear issue full", {31'd0, _alu_full}, 32'd0);
        pulses = _cdb_ready ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            step;
            pulses += _cdb_ready ? 1 : 0;
        end
        check("clear issue pulses", pulses, 0);

`ifdef ALU_SERIAL_SHIFT_EN
        drive(T_R, 4'b0101, 32'hFFFF_0000, 32'd8, 5'd7);
        step;
        _alu_ready = 1'b0;
        step; step;
        _clear = 1'b1;
        step;
        _clear = 1'b0;
        check("clear shift full", {31'd0, _alu_full}, 32'd0);
        pulses = _cdb_ready ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            step;
            pulses += _cdb_ready ? 1 : 0;
        end
        check("clear shift pulses", pulses, 0);
`else
        drive(T_R, 4'b0000, 32'd3, 32'd4, 5'd7);
        step;
        _alu_ready = 1'b0;
        _clear = 1'b1;
        step;
        _clear = 1'b0;
        check("clear cdb ready", {31'd0, _cdb_ready}, 32'd0);
        check("clear cdb value", _cdb_value, 32'd0);
`endif
        do_op("add after clear", T_R, 4'b0000, 32'd40, 32'd2, 5'd31);

        for (int n = 0; n < 250; n++) begin
            logic [6:0] t;
            case ($urandom_range(0, 5))
                0: t = T_R;
                1: t = T_I;
                2: t = T_B;
                3: t = T_LUI;
                4: t = T_JAL;
                default: t = 7'($urandom);
            endcase
            do_op($sformatf("rand%0d", n), t, 4'($urandom), $urandom, $urandom, 5'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
